// File: rtl/frac_mult_seq.sv
// Shift-add signed Q1.(n-1) multiplier: accept-to-done n+1 cycles, start ignored while busy.
// Define FRAC_MULT_ROUND_EN for round-half-up on result; default build truncates.
module frac_mult_seq #(
   parameter int n = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [n-1:0]   result,
   output logic [2*n-1:0] product
);
   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [n-1:0] MAXPOS = {1'b0, {(n-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [n-1:0]     r_a;
   logic [n-1:0]     r_b;
   logic [2*n-1:0]   r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [n-1:0]     r_result;
   logic [2*n-1:0]   r_product;

   logic [2*n-1:0]   w_pp;
   logic [2*n-1:0]   w_acc_next;
   logic             w_last;
   logic [n-1:0]     w_trunc;
   logic             w_ovf;
   logic [n-1:0]     w_result;

   assign w_last = (r_cnt == CW'(n-1));
   assign w_pp   = {{n{r_a[n-1]}}, r_a} << r_cnt;

   // The multiplier MSB carries weight -2^(n-1), so its partial product is subtracted.
   always_comb begin
      w_acc_next = r_acc;
      if (r_b[r_cnt]) begin
         if (w_last)
            w_acc_next = r_acc - w_pp;
         else
            w_acc_next = r_acc + w_pp;
      end
   end

   assign w_trunc = w_acc_next[2*n-2:n-1];
   assign w_ovf   = w_acc_next[2*n-1] ^ w_acc_next[2*n-2];

`ifdef FRAC_MULT_ROUND_EN
   logic w_rnd;
   assign w_rnd = w_acc_next[n-2];
   always_comb begin
      w_result = w_trunc + {{(n-1){1'b0}}, w_rnd};
      if (w_ovf || (w_rnd && (w_trunc == MAXPOS)))
         w_result = MAXPOS;
   end
`else
   always_comb begin
      w_result = w_trunc;
      if (w_ovf)
         w_result = MAXPOS;
   end
`endif

   // LOAD is the capture cycle; busy rises on the edge that enters RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               r_busy  <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_product <= w_acc_next;
                  r_result  <= w_result;
                  r_state   <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;
   assign product = r_product;
endmodule

// File: tb/tb_frac_mult_seq.sv
// Scoreboard bench for frac_mult_seq (n=8); expected values pushed at issue, checked on done.
module tb_frac_mult_seq;
   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [7:0]  result;
   logic [15:0] product;

   typedef struct packed {
      logic [15:0] p;
      logic [7:0]  r;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef FRAC_MULT_ROUND_EN
   localparam logic [7:0] RND_EXP = 8'h02;
`else
   localparam logic [7:0] RND_EXP = 8'h01;
`endif

   frac_mult_seq #(.n(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model_prod(input logic [7:0] aa, input logic [7:0] bb);
      logic signed [15:0] sa;
      logic signed [15:0] sb16;
      sa   = $signed(aa);
      sb16 = $signed(bb);
      return sa * sb16;
   endfunction

   function automatic logic [7:0] model_res(input logic [15:0] p);
      logic [7:0] t;
      t = p[14:7];
      if (p[15] != p[14]) return 8'h7F;
`ifdef FRAC_MULT_ROUND_EN
      if (p[6]) begin
         if (t == 8'h7F) return 8'h7F;
         return t + 8'd1;
      end
`endif
      return t;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding issue.
   always @(negedge clk) begin
      if (!reset && done) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: product=%h result=%h, no operation outstanding", product, result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (product !== e.p || result !== e.r) begin
               n_err++;
               $display("FAIL scoreboard: product=%h result=%h, expected product=%h result=%h",
                        product, result, e.p, e.r);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_op(input logic [7:0] aa, input logic [7:0] bb);
      exp_t e;
      a = aa;
      b = bb;
      start = 1'b1;
      e.p = model_prod(aa, bb);
      e.r = model_res(e.p);
      sb.push_back(e);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int cyc, output int nb, output bit to);
      cyc = 0;
      nb  = 0;
      to  = 1'b0;
      while (!done) begin
         if (cyc >= maxc) begin
            to = 1'b1;
            break;
         end
         tick();
         cyc++;
         if (busy) nb++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      a = 8'h40;
      b = 8'h40;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
         n_cmp++;
         if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
         n_cmp++;
         if (result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", result); end
         n_cmp++;
         if (product !== 16'h0000) begin n_err++; $display("FAIL reset_product: got %h want 0000", product); end
      end
      start = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int cyc, nb;
      bit to;
      start_op(8'h40, 8'h40);
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to || cyc != 9) begin n_err++; $display("FAIL basic_latency: got %0d cycles (timeout=%b) want 9", cyc, to); end
      n_cmp++;
      if (nb != 8) begin n_err++; $display("FAIL basic_busy_len: got %0d want 8", nb); end
      n_cmp++;
      if (result !== 8'h20 || product !== 16'h1000) begin
         n_err++; $display("FAIL basic_value: got %h/%h want 1000/20", product, result);
      end
      a = 8'h7F;
      b = 8'h81;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (done !== 1'b0 || result !== 8'h20 || product !== 16'h1000) begin
            n_err++; $display("FAIL output_hold: done=%b %h/%h want 0 1000/20", done, product, result);
         end
      end
   endtask

   task automatic test_signed_sat();
      logic [7:0] ta [0:6] = '{8'hC0, 8'h80, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01};
      logic [7:0] tb [0:6] = '{8'h40, 8'h80, 8'h7F, 8'h7F, 8'hFF, 8'h55, 8'h80};
      int cyc, nb;
      bit to;
      for (int i = 0; i < 7; i++) begin
         start_op(ta[i], tb[i]);
         wait_done(20, cyc, nb, to);
         n_cmp++;
         if (to) begin n_err++; $display("FAIL signed_timeout: vector %0d never completed", i); end
         if (i == 0) begin
            n_cmp++;
            if (product !== 16'hF000 || result !== 8'hE0) begin
               n_err++; $display("FAIL signed_neg: got %h/%h want F000/E0", product, result);
            end
         end
         if (i == 1) begin
            n_cmp++;
            if (product !== 16'h4000 || result !== 8'h7F) begin
               n_err++; $display("FAIL saturate: got %h/%h want 4000/7F", product, result);
            end
         end
         tick();
      end
   endtask

   task automatic test_round();
      int cyc, nb;
      bit to;
      start_op(8'h03, 8'h40);
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to || product !== 16'h00C0 || result !== RND_EXP) begin
         n_err++; $display("FAIL round: got %h/%h want 00C0/%h", product, result, RND_EXP);
      end
      tick();
   endtask

   task automatic test_start_held();
      int cyc, nb;
      bit to;
      exp_t e;
      a = 8'h40;
      b = 8'h40;
      start = 1'b1;
      e.p = 16'h1000;
      e.r = 8'h20;
      sb.push_back(e);
      for (int i = 0; i < 7; i++) begin
         tick();
         a = 8'($urandom);
         b = 8'($urandom);
      end
      start = 1'b0;
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to || cyc != 3) begin n_err++; $display("FAIL held_latency: got %0d more cycles (timeout=%b) want 3", cyc, to); end
      n_cmp++;
      if (result !== 8'h20) begin n_err++; $display("FAIL held_result: got %h want 20", result); end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL held_no_reissue: busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc, nb;
      bit to;
      start_op(8'h40, 8'h40);
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL b2b_first: timeout"); end
      start_op(8'h20, 8'h20);
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to || cyc != 9) begin n_err++; $display("FAIL b2b_latency: got %0d (timeout=%b) want 9", cyc, to); end
      n_cmp++;
      if (result !== 8'h08 || product !== 16'h0400) begin
         n_err++; $display("FAIL b2b_value: got %h/%h want 0400/08", product, result);
      end
      tick();
   endtask

   task automatic test_abort();
      int cyc, nb;
      bit to;
      start_op(8'h40, 8'h40);
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL abort_precond: busy=%b want 1", busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || result !== 8'h00) begin
         n_err++; $display("FAIL abort_clear: busy=%b done=%b %h/%h want 0 0 0000/00", busy, done, product, result);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_quiet: done=%b busy=%b want 0 0", done, busy);
         end
      end
      start_op(8'hC0, 8'h40);
      wait_done(20, cyc, nb, to);
      n_cmp++;
      if (to || cyc != 9 || product !== 16'hF000) begin
         n_err++; $display("FAIL abort_recover: cycles=%0d product=%h want 9 F000", cyc, product);
      end
      tick();
   endtask

   task automatic test_random();
      int cyc, nb;
      bit to;
      for (int i = 0; i < 24; i++) begin
         start_op(8'($urandom), 8'($urandom));
         wait_done(20, cyc, nb, to);
         n_cmp++;
         if (to || cyc != 9) begin n_err++; $display("FAIL random_latency: got %0d (timeout=%b) want 9", cyc, to); end
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      test_reset();
      test_basic();
      test_signed_sat();
      test_round();
      test_start_held();
      test_back_to_back();
      test_abort();
      test_random();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
